// File: rtl/sevenseg_scan_decoder.sv
// Receive-side decoder for a 4-digit multiplexed seven-segment bus: samples the scan,
// waits for each digit to dwell stably, decodes glyphs to BCD and flags bus errors.
module sevenseg_scan_decoder #(
    parameter int ACTIVE_LOW = 1,
    parameter int STABLE_CYC = 16,
    parameter int TIMEOUT    = 2**20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] led_seg,
    input  logic       a1,
    input  logic       a2,
    input  logic       a3,
    input  logic       a4,
    output logic [3:0] dig1,
    output logic [3:0] dig2,
    output logic [3:0] dig3,
    output logic [3:0] dig4,
    output logic [3:0] dig_valid,
    output logic       frame_done,
    output logic       ovl_err,
    output logic       bad_glyph,
    output logic       scan_lost
);

    localparam int   CW  = $clog2(STABLE_CYC + 1);
    localparam int   WW  = $clog2(TIMEOUT + 1);
    localparam logic INV = (ACTIVE_LOW != 0);

    logic [6:0]    seg_s, seg_p;
    logic [3:0]    an_s, an_p;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          captured;
    logic [WW-1:0] wd, wd_nxt;
    logic [3:0]    mask, mask_set;
    logic [3:0]    digs [4];
    logic          an_one, an_many, same, capture, expire;
    logic [1:0]    sel;
    logic [4:0]    dec;

    // Returns {bad, value}; segments are active-high, ordered g..a.
    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'b0111111: decode = 5'h00;
            7'b0000110: decode = 5'h01;
            7'b1011011: decode = 5'h02;
            7'b1001111: decode = 5'h03;
            7'b1100110: decode = 5'h04;
            7'b1101101: decode = 5'h05;
            7'b1111101: decode = 5'h06;
            7'b0000111: decode = 5'h07;
            7'b1111111: decode = 5'h08;
            7'b1101111: decode = 5'h09;
            7'b0000000: decode = 5'h0F;
            default:    decode = 5'h1E;
        endcase
    endfunction

    always_comb begin
        an_one = 1'b0;
        sel    = 2'd0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (an_s == 4'(1 << i)) begin
                an_one = 1'b1;
                sel    = 2'(i);
            end
        end
        an_many = (an_s != '0) && !an_one;
        same    = (seg_s == seg_p) && (an_s == an_p);

        if (!an_one)                         cnt_nxt = '0;
        else if (!same)                      cnt_nxt = CW'(1);
        else if (cnt == CW'(STABLE_CYC))     cnt_nxt = cnt;
        else                                 cnt_nxt = cnt + 1'b1;

        // One capture per dwell: the flag only survives while the sample stays unchanged.
        capture = an_one && (cnt_nxt == CW'(STABLE_CYC)) && !(same && captured);

        if (capture)                  wd_nxt = '0;
        else if (wd == WW'(TIMEOUT))  wd_nxt = wd;
        else                          wd_nxt = wd + 1'b1;
        expire = !capture && (wd_nxt == WW'(TIMEOUT));

        mask_set = mask | (4'b0001 << sel);
        dec      = decode(seg_s);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_s      <= '0;
            seg_p      <= '0;
            an_s       <= '0;
            an_p       <= '0;
            cnt        <= '0;
            captured   <= 1'b0;
            wd         <= '0;
            mask       <= '0;
            for (int unsigned i = 0; i < 4; i++) digs[i] <= '0;
            dig_valid  <= '0;
            frame_done <= 1'b0;
            ovl_err    <= 1'b0;
            bad_glyph  <= 1'b0;
            scan_lost  <= 1'b0;
        end else begin
            seg_s      <= led_seg ^ {7{INV}};
            an_s       <= {a4, a3, a2, a1} ^ {4{INV}};
            seg_p      <= seg_s;
            an_p       <= an_s;
            cnt        <= cnt_nxt;
            captured   <= (an_one && same) ? (captured | capture) : capture;
            wd         <= wd_nxt;
            ovl_err    <= an_many;
            bad_glyph  <= capture && dec[4];
            frame_done <= 1'b0;
            if (capture) begin
                digs[sel]      <= dec[3:0];
                dig_valid[sel] <= 1'b1;
                scan_lost      <= 1'b0;
                if (mask_set == 4'hF) begin
                    frame_done <= 1'b1;
                    mask       <= '0;
                end else begin
                    mask <= mask_set;
                end
            end else if (expire) begin
                scan_lost <= 1'b1;
                dig_valid <= '0;
                mask      <= '0;
            end
        end
    end

    assign dig1 = digs[0];
    assign dig2 = digs[1];
    assign dig3 = digs[2];
    assign dig4 = digs[3];

endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
// Directed and randomized bench for sevenseg_scan_decoder against a sample-history
// reference model (STABLE_CYC=4, TIMEOUT=64, active-low bus).
module tb_sevenseg_scan_decoder;

    localparam int SC = 4;
    localparam int TO = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] led_seg = 7'h7F;
    logic       a1 = 1'b1, a2 = 1'b1, a3 = 1'b1, a4 = 1'b1;
    logic [3:0] dig1, dig2, dig3, dig4, dig_valid;
    logic       frame_done, ovl_err, bad_glyph, scan_lost;

    sevenseg_scan_decoder #(.ACTIVE_LOW(1), .STABLE_CYC(SC), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .led_seg(led_seg),
        .a1(a1), .a2(a2), .a3(a3), .a4(a4),
        .dig1(dig1), .dig2(dig2), .dig3(dig3), .dig4(dig4),
        .dig_valid(dig_valid), .frame_done(frame_done), .ovl_err(ovl_err),
        .bad_glyph(bad_glyph), .scan_lost(scan_lost)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [6:0] glyph [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                               7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};

    // Reference model state; hist[0] is the newest sample the DUT has registered.
    logic [10:0] hist [SC+1];
    int          m_dig [4];
    logic [3:0]  m_valid, m_mask;
    int          m_since;
    logic        m_lost, m_frame, m_ovl, m_bad;
    logic [6:0]  drv_seg;
    logic [3:0]  drv_an;
    int          frame_cnt, ovl_cnt, bad_cnt, seen5;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i <= SC; i++) hist[i] = '0;
        for (int i = 0; i < 4; i++) m_dig[i] = 0;
        m_valid = '0; m_mask = '0; m_since = 0;
        m_lost = 0; m_frame = 0; m_ovl = 0; m_bad = 0;
    endtask

    function automatic int glyph_value(input logic [6:0] s);
        if (s == 7'b0) return 15;
        for (int i = 0; i < 10; i++) if (glyph[i] == s) return i;
        return 14;
    endfunction

    task automatic model_edge();
        logic [10:0] cur;
        logic        stable;
        int          idx;
        if (rst) begin
            model_reset();
            return;
        end
        cur    = hist[0];
        m_ovl  = ($countones(cur[3:0]) > 1);
        m_frame = 0;
        m_bad  = 0;
        stable = 1;
        for (int i = 1; i < SC; i++) if (hist[i] != cur) stable = 0;
        if ($countones(cur[3:0]) == 1 && stable && hist[SC] != cur) begin
            idx = 0;
            for (int i = 0; i < 4; i++) if (cur[i]) idx = i;
            m_dig[idx]   = glyph_value(cur[10:4]);
            m_bad        = (m_dig[idx] == 14);
            m_valid[idx] = 1;
            m_mask[idx]  = 1;
            if (m_mask == 4'hF) begin
                m_frame = 1;
                m_mask  = '0;
            end
            m_since = 0;
            m_lost  = 0;
        end else begin
            m_since++;
            if (m_since >= TO) begin
                m_lost  = 1;
                m_valid = '0;
                m_mask  = '0;
            end
        end
        for (int i = SC; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = {drv_seg, drv_an};
    endtask

    task automatic check_all();
        chk("digits", {dig4, dig3, dig2, dig1},
            {m_dig[3][3:0], m_dig[2][3:0], m_dig[1][3:0], m_dig[0][3:0]});
        chk("dig_valid", dig_valid, m_valid);
        chk("frame_done", frame_done, m_frame);
        chk("ovl_err", ovl_err, m_ovl);
        chk("bad_glyph", bad_glyph, m_bad);
        chk("scan_lost", scan_lost, m_lost);
        if (frame_done) frame_cnt++;
        if (ovl_err) ovl_cnt++;
        if (bad_glyph) bad_cnt++;
        if (dig2 == 4'd5) seen5++;
    endtask

    // Drive one cycle in active-high terms; the bus itself is active-low.
    task automatic cyc(input logic [6:0] seg_h, input logic [3:0] an_h);
        drv_seg = seg_h;
        drv_an  = an_h;
        led_seg = ~seg_h;
        {a4, a3, a2, a1} = ~an_h;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic hold(input logic [6:0] seg_h, input logic [3:0] an_h, input int n);
        for (int i = 0; i < n; i++) cyc(seg_h, an_h);
    endtask

    initial begin
        logic [3:0]  snap;
        logic [15:0] dsnap;
        int          r, d, len;
        logic [6:0]  g;
        logic [3:0]  an;

        model_reset();
        drv_seg = '0; drv_an = '0;
        frame_cnt = 0; ovl_cnt = 0; bad_cnt = 0; seen5 = 0;
        #12;
        check_all();
        @(negedge clk);
        rst = 1'b0;

        // 1: single digit dwell, capture on the 5th edge
        hold(glyph[3], 4'b0001, 4);
        chk("t1_no_early_capture", dig_valid, 4'b0000);
        cyc(glyph[3], 4'b0001);
        chk("t1_dig1", dig1, 4'd3);
        chk("t1_valid", dig_valid, 4'b0001);
        hold(glyph[3], 4'b0001, 5);

        // 2: full scan with blanking gaps
        frame_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            hold(7'b0, 4'b0000, 2);
            hold(glyph[i+1], 4'(1 << i), 8);
        end
        chk("t2_digits", {dig4, dig3, dig2, dig1}, 16'h4321);
        chk("t2_valid", dig_valid, 4'hF);
        chk("t2_frame_pulses", frame_cnt, 1);

        // 3: short 5 then stable 6 on a2
        seen5 = 0;
        hold(glyph[5], 4'b0010, 2);
        hold(glyph[6], 4'b0010, 6);
        chk("t3_dig2", dig2, 4'd6);
        chk("t3_never5", seen5, 0);

        // 4: overlapping anodes
        ovl_cnt = 0;
        dsnap = {dig4, dig3, dig2, dig1};
        hold(glyph[8], 4'b0101, 8);
        chk("t4_digits_hold", {dig4, dig3, dig2, dig1}, dsnap);
        chk("t4_ovl_seen", (ovl_cnt > 0), 1'b1);
        hold(7'b0, 4'b0000, 1);

        // 5: unknown glyph then watchdog expiry
        bad_cnt = 0;
        hold(7'b1010101, 4'b1000, 6);
        chk("t5_dig4", dig4, 4'hE);
        chk("t5_bad_once", bad_cnt, 1);
        hold(7'b0, 4'b0000, 64);
        chk("t5_lost", scan_lost, 1'b1);
        chk("t5_valid_clear", dig_valid, 4'b0000);

        // 6: asynchronous reset in the middle of a dwell
        hold(glyph[7], 4'b0001, 3);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("t6_async_zero", {dig4, dig3, dig2, dig1, dig_valid, frame_done, ovl_err, bad_glyph, scan_lost},
            24'h0);
        @(negedge clk);
        cyc(glyph[7], 4'b0001);
        rst = 1'b0;
        hold(glyph[7], 4'b0001, 4);
        chk("t6_no_early", dig_valid, 4'b0000);
        cyc(glyph[7], 4'b0001);
        chk("t6_dig1", dig1, 4'd7);

        // Randomized scanning with occasional bad glyphs, overlaps and long idles
        for (int it = 0; it < 400; it++) begin
            r = $urandom_range(0, 99);
            d = $urandom_range(0, 3);
            an = 4'(1 << d);
            if (r < 6) an = 4'($urandom_range(0, 15)) | an | 4'b0001;
            if (r >= 6 && r < 9) an = 4'b0000;
            r = $urandom_range(0, 99);
            if (r < 80)      g = glyph[$urandom_range(0, 9)];
            else if (r < 90) g = 7'b0;
            else             g = 7'($urandom_range(0, 127));
            len = $urandom_range(1, 8);
            hold(g, an, len);
            hold(7'b0, 4'b0000, $urandom_range(0, 2));
            if ($urandom_range(0, 49) == 0) hold(7'b0, 4'b0000, 70);
        end

        snap = dig_valid;
        hold(7'b0, 4'b0000, TO + 2);
        chk("end_lost", {scan_lost, dig_valid}, 5'b10000);
        chk("end_prev_valid_known", (^snap === 1'bx), 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
